// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb,
// drives memory handshakes and datapath strobes, raises a sticky trap, counts retirements.
module multicycle_ctrl #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TO_W    = 8,
   parameter int unsigned TIMEOUT = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             is_int_calc,
   input  logic             is_branch,
   input  logic             is_b_type,
   input  logic             is_mem_load,
   input  logic             is_mem_store,
   input  logic             is_u_type,
   input  logic             is_float_calc,
   input  logic             is_system,
   input  logic             br_taken,
   output logic             imem_req,
   input  logic             imem_rdy,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_rdy,
   output logic             ir_we,
   output logic             mdr_we,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             pc_we,
   output logic             pc_sel,
   output logic [2:0]       state,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   localparam bit             TO_EN   = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_e;

   state_e           state_q, state_d;
   logic             trap_q, trap_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic             retire;

   logic imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, mdr_we_c, rf_we_c, pc_we_c, pc_sel_c;
   logic [1:0] wb_sel_c;
   logic legal_cls, illegal, to_hit;

   assign legal_cls = is_int_calc | is_branch | is_mem_load | is_mem_store | is_u_type;
   assign illegal   = is_float_calc | is_system | ~legal_cls;
   assign to_hit    = TO_EN && (to_q == TO_LAST);

   // State, trap, retire counter and wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         trap_q    <= 1'b0;
         cause_q   <= 2'd0;
         instret_q <= '0;
         to_q      <= '0;
      end else begin
         state_q   <= state_d;
         trap_q    <= trap_d;
         cause_q   <= cause_d;
         instret_q <= instret_d;
         to_q      <= to_d;
      end
   end

   // Next state and strobes; wait counter reads zero on every entry to FETCH/MEM
   always_comb begin
      state_d    = state_q;
      trap_d     = trap_q;
      cause_d    = cause_q;
      instret_d  = instret_q;
      to_d       = '0;
      retire     = 1'b0;
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
      ir_we_c    = 1'b0;
      mdr_we_c   = 1'b0;
      rf_we_c    = 1'b0;
      wb_sel_c   = 2'd0;
      pc_we_c    = 1'b0;
      pc_sel_c   = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (imem_rdy) begin
               ir_we_c = 1'b1;
               state_d = S_DECODE;
            end else if (to_hit) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = 2'd2;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_DECODE: begin
            if (illegal) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = 2'd1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_int_calc || is_u_type) begin
               state_d = S_WB;
            end else if (is_mem_load || is_mem_store) begin
               state_d = S_MEM;
            end else if (is_branch) begin
               pc_we_c = 1'b1;
               if (is_b_type) begin
                  pc_sel_c = br_taken;
               end else begin
                  pc_sel_c = 1'b1;
                  rf_we_c  = 1'b1;
                  wb_sel_c = 2'd2;
               end
               retire  = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = 2'd1;
            end
         end
         S_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = is_mem_store;
            if (dmem_rdy) begin
               if (is_mem_store) begin
                  pc_we_c = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  mdr_we_c = 1'b1;
                  state_d  = S_WB;
               end
            end else if (to_hit) begin
               state_d = S_TRAP;
               trap_d  = 1'b1;
               cause_d = 2'd3;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         S_WB: begin
            rf_we_c  = 1'b1;
            wb_sel_c = is_mem_load ? 2'd1 : 2'd0;
            pc_we_c  = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (retire) begin
         instret_d = instret_q + CNT_W'(1);
      end
   end

   // Combinational strobes are held low during reset
   assign imem_req   = rst_n & imem_req_c;
   assign dmem_req   = rst_n & dmem_req_c;
   assign dmem_we    = rst_n & dmem_we_c;
   assign ir_we      = rst_n & ir_we_c;
   assign mdr_we     = rst_n & mdr_we_c;
   assign rf_we      = rst_n & rf_we_c;
   assign wb_sel     = {2{rst_n}} & wb_sel_c;
   assign pc_we      = rst_n & pc_we_c;
   assign pc_sel     = rst_n & pc_sel_c;
   assign state      = state_q;
   assign trap       = trap_q;
   assign trap_cause = cause_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (TIMEOUT=4): expected output vectors go through a
// scoreboard queue and are compared against the DUT once per cycle at the falling edge.
module tb_multicycle_ctrl;

   localparam logic [7:0] F_INT = 8'b1000_0000;
   localparam logic [7:0] F_BR  = 8'b0100_0000;
   localparam logic [7:0] F_BT  = 8'b0010_0000;
   localparam logic [7:0] F_LD  = 8'b0001_0000;
   localparam logic [7:0] F_ST  = 8'b0000_1000;
   localparam logic [7:0] F_U   = 8'b0000_0100;
   localparam logic [7:0] F_SYS = 8'b0000_0001;

   logic clk = 1'b0;
   logic rst_n;
   logic is_int_calc, is_branch, is_b_type, is_mem_load, is_mem_store;
   logic is_u_type, is_float_calc, is_system, br_taken;
   logic imem_req, imem_rdy, dmem_req, dmem_we, dmem_rdy;
   logic ir_we, mdr_we, rf_we, pc_we, pc_sel, trap;
   logic [1:0]  wb_sel, trap_cause;
   logic [2:0]  state;
   logic [31:0] instret;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(32), .TO_W(8), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .is_int_calc(is_int_calc), .is_branch(is_branch), .is_b_type(is_b_type),
      .is_mem_load(is_mem_load), .is_mem_store(is_mem_store), .is_u_type(is_u_type),
      .is_float_calc(is_float_calc), .is_system(is_system), .br_taken(br_taken),
      .imem_req(imem_req), .imem_rdy(imem_rdy),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_rdy(dmem_rdy),
      .ir_we(ir_we), .mdr_we(mdr_we), .rf_we(rf_we), .wb_sel(wb_sel),
      .pc_we(pc_we), .pc_sel(pc_sel), .state(state),
      .trap(trap), .trap_cause(trap_cause), .instret(instret)
   );

   typedef struct {
      string       tag;
      logic [47:0] v;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [47:0] obs;

   assign obs = {instret, state, imem_req, dmem_req, dmem_we, ir_we, mdr_we, rf_we,
                 wb_sel, pc_we, pc_sel, trap, trap_cause};

   function automatic logic [47:0] mk(input logic [2:0] st, input logic ireq, input logic dreq,
                                      input logic dwe, input logic irwe, input logic mdrwe,
                                      input logic rfwe, input logic [1:0] wbs, input logic pcwe,
                                      input logic pcsel, input logic tr, input logic [1:0] tc,
                                      input logic [31:0] ir);
      return {ir, st, ireq, dreq, dwe, irwe, mdrwe, rfwe, wbs, pcwe, pcsel, tr, tc};
   endfunction

   task automatic push(input string tag, input logic [47:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic step(input string tag, input logic [47:0] v);
      push(tag, v);
      @(negedge clk);
      check_now();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic [7:0] f);
      {is_int_calc, is_branch, is_b_type, is_mem_load, is_mem_store,
       is_u_type, is_float_calc, is_system} = f;
   endtask

   task automatic fetch(input logic [31:0] ir);
      set_flags(8'h00);
      imem_rdy = 1'b1;
      step("fetch", mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, ir));
      imem_rdy = 1'b0;
   endtask

   task automatic pulse_reset();
      imem_rdy = 1'b0;
      dmem_rdy = 1'b0;
      set_flags(8'h00);
      rst_n = 1'b0;
      #1;
      push("reset_async", mk(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'd0));
      check_now();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      imem_rdy = 1'b0;
      dmem_rdy = 1'b0;
      br_taken = 1'b0;
      set_flags(8'h00);
      #12;
      push("reset", mk(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'd0));
      check_now();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ADD
      fetch(0);
      set_flags(F_INT);
      step("add_dec",  mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
      step("add_exec", mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
      step("add_wb",   mk(3'd4, 0, 0, 0, 0, 0, 1, 2'd0, 1, 0, 0, 2'd0, 0));

      // LW, dmem_rdy on the 4th MEM cycle (also the timeout boundary)
      fetch(1);
      set_flags(F_LD);
      step("lw_dec",  mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1));
      step("lw_exec", mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1));
      for (int i = 0; i < 3; i++)
         step("lw_wait", mk(3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1));
      dmem_rdy = 1'b1;
      step("lw_rdy", mk(3'd3, 0, 1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 1));
      dmem_rdy = 1'b0;
      step("lw_wb",  mk(3'd4, 0, 0, 0, 0, 0, 1, 2'd1, 1, 0, 0, 2'd0, 1));

      // BEQ not taken, BEQ taken, JAL
      fetch(2);
      set_flags(F_BR | F_BT);
      br_taken = 1'b0;
      step("beq_nt_dec",  mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2));
      step("beq_nt_exec", mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 2));
      fetch(3);
      set_flags(F_BR | F_BT);
      br_taken = 1'b1;
      step("beq_t_dec",  mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 3));
      step("beq_t_exec", mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 2'd0, 3));
      fetch(4);
      set_flags(F_BR);
      br_taken = 1'b0;
      step("jal_dec",  mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 4));
      step("jal_exec", mk(3'd2, 0, 0, 0, 0, 0, 1, 2'd2, 1, 1, 0, 2'd0, 4));

      // SW, immediate dmem_rdy
      fetch(5);
      set_flags(F_ST);
      step("sw_dec",  mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 5));
      step("sw_exec", mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 5));
      dmem_rdy = 1'b1;
      step("sw_mem",  mk(3'd3, 0, 1, 1, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 5));
      dmem_rdy = 1'b0;

      // LUI
      fetch(6);
      set_flags(F_U);
      step("lui_dec",  mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 6));
      step("lui_exec", mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 6));
      step("lui_wb",   mk(3'd4, 0, 0, 0, 0, 0, 1, 2'd0, 1, 0, 0, 2'd0, 6));

      // Fetch accepted on the last allowed wait cycle: no trap
      set_flags(8'h00);
      for (int i = 0; i < 3; i++)
         step("fetch_wait", mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 7));
      imem_rdy = 1'b1;
      step("fetch_late_rdy", mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 7));
      imem_rdy = 1'b0;

      // System op traps with cause 1 and holds
      set_flags(F_SYS);
      step("sys_dec", mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 7));
      imem_rdy = 1'b1;
      dmem_rdy = 1'b1;
      for (int i = 0; i < 50; i++)
         step("sys_trap", mk(3'd7, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 7));

      // Fetch timeout, cause 2
      pulse_reset();
      for (int i = 0; i < 4; i++)
         step("ito_wait", mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
      imem_rdy = 1'b1;
      for (int i = 0; i < 3; i++)
         step("ito_trap", mk(3'd7, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 0));

      // Data timeout, cause 3
      pulse_reset();
      fetch(0);
      set_flags(F_LD);
      step("dto_dec",  mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
      step("dto_exec", mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
      for (int i = 0; i < 4; i++)
         step("dto_wait", mk(3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
      dmem_rdy = 1'b1;
      for (int i = 0; i < 2; i++)
         step("dto_trap", mk(3'd7, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd3, 0));

      // Reset pulsed in the middle of a load's MEM phase
      pulse_reset();
      fetch(0);
      set_flags(F_INT);
      step("add2_dec",  mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
      step("add2_exec", mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
      step("add2_wb",   mk(3'd4, 0, 0, 0, 0, 0, 1, 2'd0, 1, 0, 0, 2'd0, 0));
      fetch(1);
      set_flags(F_LD);
      step("lw2_dec",  mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1));
      step("lw2_exec", mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1));
      step("lw2_wait", mk(3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1));
      rst_n = 1'b0;
      #1;
      push("mid_mem_reset", mk(3'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));
      check_now();
      set_flags(8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("post_reset_fetch", mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle RV32I core. It sequences fetch, decode, execute, memory and writeback around the instruction decoder, register file, ALU and memories.
- Consumes the decoder class flags and drives the instruction/data memory handshakes, datapath write enables and mux selects.
- Raises a sticky trap on an illegal instruction class or a memory timeout, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TO_W, 8, width of memory-wait timeout counter.
- TIMEOUT, 200, wait cycles without ready before trapping; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- is_int_calc  in  1  decoder: R/I integer calc.
- is_branch  in  1  decoder: B-type, JAL or JALR.
- is_b_type  in  1  decoder: conditional branch.
- is_mem_load  in  1  decoder: load.
- is_mem_store  in  1  decoder: store.
- is_u_type  in  1  decoder: LUI/AUIPC.
- is_float_calc  in  1  decoder: float op (unsupported).
- is_system  in  1  decoder: system op (unsupported).
- br_taken  in  1  ALU compare result for B-type.
- imem_req  out  1  instruction fetch request.
- imem_rdy  in  1  fetch accepted; instruction data valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_rdy  in  1  data access complete; load data valid this cycle.
- ir_we  out  1  load instruction register.
- mdr_we  out  1  load memory data register.
- rf_we  out  1  register file write.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = MDR, 2 = PC+4.
- pc_we  out  1  update PC.
- pc_sel  out  1  next PC source: 0 = PC+4, 1 = branch/jump target.
- state  out  3  current state code.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  fault code: 1 = illegal, 2 = imem timeout, 3 = dmem timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- **Reset and output style**
  - Registered elements: state, trap, trap_cause, instret and the timeout counter. All reset asynchronously to FETCH / 0.
  - All other outputs are combinational from state, the decoder flags and rdy. They are forced to 0 while rst_n is low.
- **State codes:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- **FETCH**
  - imem_req=1 until imem_rdy.
  - In the imem_rdy cycle: ir_we=1, next state DECODE.
- **DECODE** (1 cycle)
  - Decoder flags are valid from DECODE through WB; the IR is held.
  - is_float_calc or is_system, or none of {int_calc, branch, mem_load, mem_store, u_type} set → TRAP, cause 1.
  - Otherwise → EXEC.
- **EXEC** (1 cycle)
  - int_calc or u_type → WB.
  - Load or store → MEM.
  - Branch, retiring in EXEC:
    - pc_we=1.
    - is_b_type: pc_sel=br_taken.
    - Jump (is_branch & !is_b_type): pc_sel=1, rf_we=1, wb_sel=2.
    - instret+1, next state FETCH.
- **MEM**
  - dmem_req=1 and dmem_we=is_mem_store, held until dmem_rdy.
  - Store on rdy: pc_we=1, pc_sel=0, instret+1, next state FETCH.
  - Load on rdy: mdr_we=1, next state WB.
- **WB** (1 cycle)
  - rf_we=1, wb_sel = is_mem_load ? 1 : 0.
  - pc_we=1, pc_sel=0, instret+1, next state FETCH.
- **TRAP**
  - All strobes and requests are 0; trap=1 and trap_cause are held.
  - Exit only via reset.
- **Timeout**
  - The counter clears on entry to FETCH or MEM and increments each cycle the request is not accepted.
  - When the counter equals TIMEOUT-1 and rdy=0 → TRAP with cause 2 (FETCH) or 3 (MEM).
  - rdy in that same cycle wins: no trap.
  - TIMEOUT=0 disables the timeout entirely.
- **Counters and wrap**
  - instret wraps modulo 2^CNT_W.
  - Exactly one increment per retired instruction; none on trap.
- **Request hold:** imem_req/dmem_req stay continuously high from state entry until rdy. They are never dropped early.
- **Reset mid-operation:** asynchronous return to FETCH. The outstanding request is abandoned and the requester must tolerate this.

Test Plan:
- ADD (is_int_calc), imem_rdy on the first request cycle:
  - States 0→1→2→4→0.
  - rf_we=1 with wb_sel=0 in WB only.
  - instret 0→1.
- LW with dmem_rdy delayed 3 cycles:
  - dmem_req=1, dmem_we=0 for 4 cycles.
  - mdr_we on the rdy cycle, then WB with wb_sel=1; instret+1.
- BEQ with br_taken=0, then with br_taken=1:
  - EXEC shows pc_we=1 with pc_sel=0, then pc_sel=1.
  - rf_we=0 in both.
  - JAL: pc_sel=1, rf_we=1, wb_sel=2.
- is_system=1 at DECODE:
  - trap=1, cause=1, state=7 and held for 50 cycles.
  - No strobes; instret unchanged.
- TIMEOUT=4, imem_rdy held at 0:
  - TRAP cause 2 after 4 request cycles.
  - Repeat with rdy in the 4th cycle → no trap.
- rst_n pulsed low mid-MEM:
  - All outputs 0 asynchronously; instret=0.
  - After release, state=FETCH and imem_req=1.
